// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use bubbles, redirect
// flushes, data-memory freeze with timeout watchdog, and saturating event counters.
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             memwb_bubble,
   output logic             dmem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [0:0] RUN      = 1'b0;
   localparam logic [0:0] MEM_WAIT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WC_W-1:0]  wait_q, wait_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic luh, freeze, redirect, lu_stall;

   // Qualifying with reset forces the default enables while reset is held.
   always_comb begin
      luh = ex_memread && (ex_rd != 5'd0) &&
            ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
      freeze   = !reset && mem_access && !dmem_ready;
      redirect = !reset && ex_redirect && !freeze;
      lu_stall = !reset && luh && !freeze && !ex_redirect;
   end

   always_comb begin
      pc_write     = !freeze && !lu_stall;
      ifid_write   = !freeze && !lu_stall;
      ifid_flush   = redirect;
      idex_write   = !freeze;
      idex_flush   = redirect || lu_stall;
      exmem_write  = !freeze;
      memwb_bubble = freeze;
      dmem_req     = !reset && mem_access;
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      case (state_q)
         RUN: begin
            if (freeze) begin
               state_d = MEM_WAIT;
               wait_d  = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!freeze) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == WC_W'(MEM_TIMEOUT)) begin
               mem_err_d = 1'b1;
            end else begin
               wait_d = wait_q + WC_W'(1);
            end
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if ((freeze || lu_stall) && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + CNT_W'(1);
      if (redirect && (flush_q != {CNT_W{1'b1}}))
         flush_d = flush_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table for the combinational
// priority logic plus hand-written multi-cycle memory, timeout and reset sequences.
module tb_hazard_stall_ctrl;

   localparam int CNT_W = 3;

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble, dmem_req}
   localparam logic [7:0] IDLE = 8'b1101_0100;
   localparam logic [7:0] LU   = 8'b0001_1100;
   localparam logic [7:0] RD   = 8'b1111_1100;
   localparam logic [7:0] FRZ  = 8'b0000_0011;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_access, dmem_ready;
   logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
   logic memwb_bubble, dmem_req, mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [7:0] outv;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
      .memwb_bubble(memwb_bubble), .dmem_req(dmem_req), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign outv = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                  exmem_write, memwb_bubble, dmem_req};

   typedef struct {
      logic [4:0] rs1, rs2;
      logic       u1, u2, mr;
      logic [4:0] rd;
      logic       redir, macc, rdy;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic redir,
                               input logic macc, input logic rdy, input logic [7:0] exp);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr;
      v.rd = rd; v.redir = redir; v.macc = macc; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
      ex_memread = v.mr; ex_rd = v.rd; ex_redirect = v.redir;
      mem_access = v.macc; dmem_ready = v.rdy;
   endtask

   task automatic idle();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
   endtask

   // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_stall, exp_flush;

      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
      tbl[1]  = mk(5, 0, 1, 0, 1, 5, 0, 0, 0, LU);
      tbl[2]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, IDLE);
      tbl[3]  = mk(3, 5, 1, 0, 1, 5, 0, 0, 0, IDLE);
      tbl[4]  = mk(3, 5, 1, 1, 1, 5, 0, 0, 0, LU);
      tbl[5]  = mk(5, 0, 1, 0, 1, 5, 1, 0, 0, RD);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, RD);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE | 8'h01);
      tbl[8]  = mk(5, 0, 1, 0, 1, 5, 0, 1, 1, LU | 8'h01);
      tbl[9]  = mk(5, 0, 1, 0, 1, 5, 1, 1, 0, FRZ);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, RD);
      tbl[11] = mk(5, 5, 1, 1, 0, 5, 0, 0, 0, IDLE);

      // Reset state, with a pending memory access that must not be requested.
      reset = 1'b1;
      apply(mk(5, 0, 1, 0, 1, 5, 1, 1, 0, IDLE));
      #3;
      chk("reset_outputs", outv, IDLE);
      chk("reset_stall_cnt", stall_cnt, 0);
      chk("reset_flush_cnt", flush_cnt, 0);
      chk("reset_mem_err", mem_err, 0);
      do_reset();

      // Table-driven combinational priority checks, counters tallied from expectations.
      exp_stall = 0;
      exp_flush = 0;
      foreach (tbl[i]) begin
         next_cycle();
         apply(tbl[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_outputs", i), outv, tbl[i].exp);
         if (!tbl[i].exp[7]) exp_stall++;
         if (tbl[i].exp[5])  exp_flush++;
      end
      next_cycle();
      idle();
      chk("table_stall_cnt", stall_cnt, exp_stall);
      chk("table_flush_cnt", flush_cnt, exp_flush);

      // Load-use gives exactly one bubble once the bubble clears ex_memread.
      do_reset();
      next_cycle();
      apply(tbl[1]);
      @(negedge clk);
      chk("lu_bubble", outv, LU);
      next_cycle();
      idle();
      @(negedge clk);
      chk("lu_after", outv, IDLE);
      chk("lu_stall_cnt", stall_cnt, 1);

      // Three wait cycles, release on the fourth.
      do_reset();
      for (int j = 1; j <= 3; j++) begin
         next_cycle();
         apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
         @(negedge clk);
         chk($sformatf("mw_freeze%0d", j), outv, FRZ);
      end
      next_cycle();
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("mw_release", outv, IDLE | 8'h01);
      next_cycle();
      idle();
      @(negedge clk);
      chk("mw_stall_cnt", stall_cnt, 3);
      chk("mw_mem_err", mem_err, 0);

      // Timeout: redirect first so flush_cnt is nonzero, then a 10-cycle wait.
      do_reset();
      next_cycle();
      apply(tbl[6]);
      @(negedge clk);
      chk("to_redirect", outv, RD);
      for (int j = 1; j <= 10; j++) begin
         next_cycle();
         apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
         @(negedge clk);
         chk($sformatf("to_freeze%0d", j), outv, FRZ);
         if (j <= 4) chk($sformatf("to_err_low%0d", j), mem_err, 0);
         if (j >= 6) chk($sformatf("to_err_high%0d", j), mem_err, 1);
      end
      next_cycle();
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("to_release", outv, IDLE | 8'h01);
      next_cycle();
      idle();
      @(negedge clk);
      chk("to_resume", outv, IDLE);
      chk("to_err_sticky", mem_err, 1);
      chk("to_stall_sat", stall_cnt, 7);
      chk("to_flush_cnt", flush_cnt, 1);

      // Async reset asserted between edges while waiting on memory.
      for (int j = 1; j <= 2; j++) begin
         next_cycle();
         apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
      end
      #2;
      reset = 1'b1;
      #1;
      chk("ar_outputs", outv, IDLE);
      chk("ar_stall_cnt", stall_cnt, 0);
      chk("ar_flush_cnt", flush_cnt, 0);
      chk("ar_mem_err", mem_err, 0);
      @(posedge clk);
      @(negedge clk);
      chk("ar_held_outputs", outv, IDLE);
      reset = 1'b0;
      mem_access = 1'b0;
      next_cycle();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE | 8'h01));
      @(negedge clk);
      chk("ar_zero_wait", outv, IDLE | 8'h01);
      next_cycle();
      idle();
      @(negedge clk);
      chk("ar_post_stall_cnt", stall_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the main decoder and drives the write-enable and flush inputs of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
Resolves load-use hazards with a one-cycle bubble and flushes wrong-path instructions on taken branches/jumps.
Freezes the pipeline while a multi-cycle data memory access is outstanding, with a timeout watchdog.
Keeps saturating stall and flush event counters for performance debug.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before mem_err is raised (>=1)
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 field of the instruction in ID
id_rs2  in  5  rs2 field of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  MemRead of the instruction in EX
ex_rd  in  5  destination register of the instruction in EX
ex_redirect  in  1  taken branch, JAL or JALR resolved in EX
mem_access  in  1  MEM-stage instruction has MemRead or MemWrite
dmem_ready  in  1  data memory completes the current access this cycle
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads a NOP
idex_write  out  1  ID/EX register enable
idex_flush  out  1  ID/EX loads a bubble (all control bits 0)
exmem_write  out  1  EX/MEM register enable
memwb_bubble  out  1  MEM/WB captures a bubble
dmem_req  out  1  data memory request strobe
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of redirect flushes

Behaviour:
- States: RUN, MEM_WAIT. Reset: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- All enable/flush outputs are combinational from state and inputs.
- Output defaults: all *_write=1; ifid_flush=idex_flush=memwb_bubble=0.
- Outputs during reset assertion: defaults apply, and dmem_req=0.
- dmem_req = mem_access, in both states.
- Load-use hazard: luh = ex_memread & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- Priority in each cycle: memory freeze > redirect > load-use.
- Memory freeze condition: mem_access & !dmem_ready, in either state.
  - pc_write, ifid_write, idex_write and exmem_write are all 0.
  - memwb_bubble = 1.
  - Redirect and luh are ignored; EX is held, so they are re-evaluated after release.
- Redirect (no freeze): ifid_flush=1, idex_flush=1, pc_write=1 (target loads), flush_cnt+1.
- Load-use (no freeze, no redirect): pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble, because the bubble clears ex_memread in the next cycle.
- Transitions:
  - RUN -> MEM_WAIT on a freeze, with wait_cnt=1.
  - MEM_WAIT -> RUN when dmem_ready=1 or mem_access=0; wait_cnt=0.
  - While in MEM_WAIT with the freeze condition still true, wait_cnt increments, saturating at MEM_TIMEOUT.
- Release cycle: when dmem_ready arrives in MEM_WAIT, there is no freeze that cycle and the pipeline advances. Redirect/luh are evaluated normally in that same cycle.
- Timeout: when wait_cnt==MEM_TIMEOUT and the freeze is still true, mem_err is set to 1. mem_err is cleared only by reset. The freeze continues; mem_err never breaks the stall.
- stall_cnt increments in every cycle where a freeze or a load-use stall is active. It saturates at all-ones.
- flush_cnt saturates at all-ones.
- dmem_ready=1 in the same cycle mem_access rises: zero-wait access, no freeze, state stays RUN.
- ex_rd==0 never causes a load-use stall.
- Reset asserted mid-MEM_WAIT: state returns to RUN immediately (asynchronous). Counters and mem_err clear.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle, then ex_memread=0 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1.
- x0 and unused-operand guard: same as above but ex_rd=0 -> no stall. Separately, ex_rd=5, id_rs2=5, id_use_rs2=0 -> no stall.
- Redirect over load-use: ex_redirect=1 and luh=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- Multi-cycle memory: mem_access=1, dmem_ready low for 3 cycles then high -> 3 cycles with all *_write=0 and memwb_bubble=1, release in the 4th cycle, state=RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low for 10 cycles -> mem_err rises on the cycle when wait_cnt==4 and stays high. After dmem_ready, the pipeline resumes and mem_err remains 1 until reset.
- Async reset: assert reset mid-MEM_WAIT between clock edges -> state=RUN, stall_cnt=0, flush_cnt=0 and mem_err=0 immediately. All *_write=1 and dmem_req=0 while reset is held.
